// File: rtl/snake_state_publisher_pkg.sv
// Shared layout of the 740-bit snake_data bus: field offsets, widths, write-port
// address map and reset image. The VGA controller imports the same offsets.
package snake_pkg;

   localparam int unsigned BODY_SEGS   = 10;
   localparam int unsigned POS_W       = 11;
   localparam int unsigned DIR_ENTRIES = 100;
   localparam int unsigned DIR_W       = 2;
   localparam int unsigned FIELD_W     = 32;
   localparam int unsigned DATA_W      = 740;
   localparam int unsigned DIR_BITS    = DIR_ENTRIES * DIR_W;
   localparam int unsigned BODY_BITS   = BODY_SEGS * POS_W;

   localparam int unsigned BOARD_W     = 40;
   localparam int unsigned BOARD_CELLS = 1600;
   // Off-board sentinel; any value above BOARD_CELLS-1 is never drawn.
   localparam logic [POS_W-1:0] EMPTY_POS = 11'd2047;

   localparam int unsigned OFF_DIR      = 0;
   localparam int unsigned OFF_HEAD1POS = 200;
   localparam int unsigned OFF_HEAD2POS = 232;
   localparam int unsigned OFF_LEN1     = 264;
   localparam int unsigned OFF_LEN2     = 296;
   localparam int unsigned OFF_STAGE    = 328;
   localparam int unsigned OFF_HEAD1    = 360;
   localparam int unsigned OFF_HEAD2    = 392;
   localparam int unsigned OFF_APPLE    = 424;
   localparam int unsigned OFF_HEARTS   = 456;
   localparam int unsigned OFF_RSVD     = 488;
   localparam int unsigned OFF_BODY1    = 520;
   localparam int unsigned OFF_BODY2    = 630;

   localparam logic [7:0] ADDR_STAGE    = 8'h00;
   localparam logic [7:0] ADDR_HEAD1POS = 8'h01;
   localparam logic [7:0] ADDR_HEAD2POS = 8'h02;
   localparam logic [7:0] ADDR_LEN1     = 8'h03;
   localparam logic [7:0] ADDR_LEN2     = 8'h04;
   localparam logic [7:0] ADDR_HEAD1    = 8'h05;
   localparam logic [7:0] ADDR_HEAD2    = 8'h06;
   localparam logic [7:0] ADDR_APPLE    = 8'h07;
   localparam logic [7:0] ADDR_HEARTS   = 8'h08;
   localparam logic [7:0] ADDR_BODY1    = 8'h10;
   localparam logic [7:0] ADDR_BODY2    = 8'h20;
   localparam logic [7:0] ADDR_DIR      = 8'h80;
   localparam logic [7:0] ADDR_DIR_LAST = 8'hE3;

   typedef enum logic [1:0] {
      STAGE_MENU = 2'd0,
      STAGE_PLAY = 2'd2,
      STAGE_OVER = 2'd3
   } stage_e;

   typedef enum logic {
      ST_IDLE,
      ST_PEND
   } pub_state_e;

   typedef struct packed {
      logic [FIELD_W-1:0]                      stage;
      logic [FIELD_W-1:0]                      head1pos;
      logic [FIELD_W-1:0]                      head2pos;
      logic [FIELD_W-1:0]                      len1;
      logic [FIELD_W-1:0]                      len2;
      logic [FIELD_W-1:0]                      head1;
      logic [FIELD_W-1:0]                      head2;
      logic [FIELD_W-1:0]                      apple;
      logic [FIELD_W-1:0]                      hearts;
      logic [BODY_SEGS-1:0][POS_W-1:0]         body1;
      logic [BODY_SEGS-1:0][POS_W-1:0]         body2;
      logic [DIR_ENTRIES-1:0][DIR_W-1:0]       dir;
   } snake_fields_t;

   function automatic snake_fields_t fields_reset();
      snake_fields_t f;
      f       = '0;
      f.apple = FIELD_W'(EMPTY_POS);
      f.body1 = {BODY_SEGS{EMPTY_POS}};
      f.body2 = {BODY_SEGS{EMPTY_POS}};
      return f;
   endfunction

endpackage

// File: rtl/snake_state_publisher_if.sv
// Game-logic side of the publisher: addressed shadow writes plus commit handshake.
interface snake_state_publisher_if;

   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        wr_err;
   logic        commit_req;
   logic        commit_busy;
   logic        commit_done;

   modport master (
      output wr_en, wr_addr, wr_data, commit_req,
      input  wr_ready, wr_err, commit_busy, commit_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, commit_req,
      output wr_ready, wr_err, commit_busy, commit_done
   );

endinterface

// File: rtl/snake_state_publisher_field_pack.sv
// Purely combinational mapping of the field struct onto the 740-bit snake_data layout.
module snake_field_pack
   import snake_pkg::*;
(
   input  snake_fields_t       fields_i,
   output logic [DATA_W-1:0]   data_o
);

   always_comb begin
      data_o                          = '0;
      data_o[OFF_DIR      +: DIR_BITS]  = fields_i.dir;
      data_o[OFF_HEAD1POS +: FIELD_W]   = fields_i.head1pos;
      data_o[OFF_HEAD2POS +: FIELD_W]   = fields_i.head2pos;
      data_o[OFF_LEN1     +: FIELD_W]   = fields_i.len1;
      data_o[OFF_LEN2     +: FIELD_W]   = fields_i.len2;
      data_o[OFF_STAGE    +: FIELD_W]   = fields_i.stage;
      data_o[OFF_HEAD1    +: FIELD_W]   = fields_i.head1;
      data_o[OFF_HEAD2    +: FIELD_W]   = fields_i.head2;
      data_o[OFF_APPLE    +: FIELD_W]   = fields_i.apple;
      data_o[OFF_HEARTS   +: FIELD_W]   = fields_i.hearts;
      data_o[OFF_RSVD     +: FIELD_W]   = '0;
      data_o[OFF_BODY1    +: BODY_BITS] = fields_i.body1;
      data_o[OFF_BODY2    +: BODY_BITS] = fields_i.body2;
   end

endmodule

// File: rtl/snake_state_publisher.sv
// Shadow/published double buffer for snake_data; a requested commit is applied
// only on the next falling edge of vsync so the display never sees a torn frame.
module snake_state_publisher
   import snake_pkg::*;
(
   input  logic                    iVGA_CLK,
   input  logic                    iRST_n,
   input  logic                    iVS,
   snake_state_publisher_if.slave  wr_bus,
   output logic [DATA_W-1:0]       snake_data,
   output logic [15:0]             frame_count
);

   pub_state_e    state_q, state_d;
   snake_fields_t shadow_q, shadow_d;
   snake_fields_t pub_q;
   logic          vs_q;
   logic          vs_fall;
   logic          wr_ready;
   logic          commit_busy;
   logic          publish;
   logic          wr_accept;
   logic          addr_hit;
   logic          wr_err_q;
   logic          commit_done_q;
   logic [15:0]   frame_q;
   logic [6:0]    dir_idx;

   assign vs_fall   = vs_q & ~iVS;
   assign wr_accept = wr_bus.wr_en & wr_ready;
   assign dir_idx   = 7'(wr_bus.wr_addr - ADDR_DIR);

   always_comb begin
      state_d     = state_q;
      wr_ready    = 1'b0;
      commit_busy = 1'b0;
      publish     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            wr_ready = 1'b1;
            if (wr_bus.commit_req) state_d = ST_PEND;
         end
         ST_PEND: begin
            commit_busy = 1'b1;
            if (vs_fall) begin
               publish = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      shadow_d = shadow_q;
      addr_hit = 1'b0;
      if (wr_accept) begin
         addr_hit = 1'b1;
         unique case (wr_bus.wr_addr)
            ADDR_STAGE:    shadow_d.stage    = wr_bus.wr_data;
            ADDR_HEAD1POS: shadow_d.head1pos = wr_bus.wr_data;
            ADDR_HEAD2POS: shadow_d.head2pos = wr_bus.wr_data;
            ADDR_LEN1:     shadow_d.len1     = wr_bus.wr_data;
            ADDR_LEN2:     shadow_d.len2     = wr_bus.wr_data;
            ADDR_HEAD1:    shadow_d.head1    = wr_bus.wr_data;
            ADDR_HEAD2:    shadow_d.head2    = wr_bus.wr_data;
            ADDR_APPLE:    shadow_d.apple    = wr_bus.wr_data;
            ADDR_HEARTS:   shadow_d.hearts   = wr_bus.wr_data;
            default: begin
               // Ranged regions: body tables use the low nibble, directions an offset.
               if (wr_bus.wr_addr[7:4] == ADDR_BODY1[7:4] && wr_bus.wr_addr[3:0] <= 4'd9)
                  shadow_d.body1[wr_bus.wr_addr[3:0]] = wr_bus.wr_data[POS_W-1:0];
               else if (wr_bus.wr_addr[7:4] == ADDR_BODY2[7:4] && wr_bus.wr_addr[3:0] <= 4'd9)
                  shadow_d.body2[wr_bus.wr_addr[3:0]] = wr_bus.wr_data[POS_W-1:0];
               else if (wr_bus.wr_addr >= ADDR_DIR && wr_bus.wr_addr <= ADDR_DIR_LAST)
                  shadow_d.dir[dir_idx] = wr_bus.wr_data[DIR_W-1:0];
               else
                  addr_hit = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q       <= ST_IDLE;
         vs_q          <= 1'b1;
         shadow_q      <= fields_reset();
         pub_q         <= fields_reset();
         wr_err_q      <= 1'b0;
         commit_done_q <= 1'b0;
         frame_q       <= '0;
      end else begin
         state_q       <= state_d;
         vs_q          <= iVS;
         shadow_q      <= shadow_d;
         wr_err_q      <= wr_accept & ~addr_hit;
         commit_done_q <= publish;
         if (publish) pub_q <= shadow_q;
         if (vs_fall) frame_q <= frame_q + 16'd1;
      end
   end

   snake_field_pack u_pack (
      .fields_i (pub_q),
      .data_o   (snake_data)
   );

   assign frame_count        = frame_q;
   assign wr_bus.wr_ready    = wr_ready;
   assign wr_bus.wr_err      = wr_err_q;
   assign wr_bus.commit_busy = commit_busy;
   assign wr_bus.commit_done = commit_done_q;

endmodule

// File: tb/tb_snake_state_publisher.sv
// Scoreboarded bench for snake_state_publisher: each accepted commit pushes the
// bench's own shadow image, popped and compared when commit_done fires.
module tb_snake_state_publisher;

   localparam int W = 740;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vs = 1'b1;
   logic [W-1:0]  snake_data;
   logic [15:0]   frame_count;

   snake_state_publisher_if pub_if ();

   snake_state_publisher dut (
      .iVGA_CLK    (clk),
      .iRST_n      (rst_n),
      .iVS         (vs),
      .wr_bus      (pub_if.slave),
      .snake_data  (snake_data),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int unsigned  n_checks = 0;
   int unsigned  n_fail = 0;
   logic [W-1:0] m_shadow;
   logic [W-1:0] sb_q[$];
   logic [W-1:0] prev_data = '0;
   bit           pend = 0;
   int unsigned  exp_err = 0, err_seen = 0, done_seen = 0, exp_frames = 0, done_base;

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] reset_image();
      logic [W-1:0] r = '0;
      for (int i = 0; i < 20; i++) r[520 + 11*i +: 11] = 11'h7FF;
      r[455:424] = 32'd2047;
      return r;
   endfunction

   task automatic model_write(input logic [7:0] a, input logic [31:0] d, output bit mapped);
      int idx;
      mapped = 1;
      case (a)
         8'h00: m_shadow[359:328] = d;
         8'h01: m_shadow[231:200] = d;
         8'h02: m_shadow[263:232] = d;
         8'h03: m_shadow[295:264] = d;
         8'h04: m_shadow[327:296] = d;
         8'h05: m_shadow[391:360] = d;
         8'h06: m_shadow[423:392] = d;
         8'h07: m_shadow[455:424] = d;
         8'h08: m_shadow[487:456] = d;
         default: begin
            if (a >= 8'h10 && a <= 8'h19) begin
               idx = int'(a) - 16;
               m_shadow[520 + 11*idx +: 11] = d[10:0];
            end else if (a >= 8'h20 && a <= 8'h29) begin
               idx = int'(a) - 32;
               m_shadow[630 + 11*idx +: 11] = d[10:0];
            end else if (a >= 8'h80 && a <= 8'hE3) begin
               idx = int'(a) - 128;
               m_shadow[2*idx +: 2] = d[1:0];
            end else begin
               mapped = 0;
            end
         end
      endcase
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_commit();
      if (!pend) begin
         sb_q.push_back(m_shadow);
         pend = 1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input bit with_commit);
      bit mapped;
      pub_if.wr_en      = 1'b1;
      pub_if.wr_addr    = a;
      pub_if.wr_data    = d;
      pub_if.commit_req = with_commit;
      if (!pend) begin
         model_write(a, d, mapped);
         if (!mapped) exp_err++;
      end
      if (with_commit) push_commit();
      tick(1);
      pub_if.wr_en      = 1'b0;
      pub_if.commit_req = 1'b0;
   endtask

   task automatic commit();
      pub_if.commit_req = 1'b1;
      push_commit();
      tick(1);
      pub_if.commit_req = 1'b0;
   endtask

   task automatic vsync();
      vs = 1'b0;
      exp_frames++;
      tick(3);
      vs = 1'b1;
      tick(2);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (pub_if.wr_err) err_seen++;
         if (pub_if.commit_done) begin
            done_seen++;
            check_eq("sb_depth", W'(sb_q.size()), W'(1));
            if (sb_q.size() > 0) check_eq("publish", snake_data, sb_q.pop_front());
            pend = 0;
         end
         if (snake_data !== prev_data) check_eq("change_only_on_done", W'(pub_if.commit_done), W'(1));
      end
      prev_data = snake_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
   wr_t tbl[12];

   initial begin
      pub_if.wr_en      = 1'b0;
      pub_if.wr_addr    = '0;
      pub_if.wr_data    = '0;
      pub_if.commit_req = 1'b0;
      m_shadow          = reset_image();
      tick(3);
      rst_n = 1'b1;

      // reset state
      @(negedge clk);
      check_eq("rst_data", snake_data, reset_image());
      check_eq("rst_wr_ready", W'(pub_if.wr_ready), W'(1));
      check_eq("rst_busy", W'(pub_if.commit_busy), W'(0));
      check_eq("rst_done", W'(pub_if.commit_done), W'(0));
      check_eq("rst_err", W'(pub_if.wr_err), W'(0));
      check_eq("rst_frames", W'(frame_count), W'(0));
      tick(1);

      // basic commit, last write coincides with commit_req
      wr(8'h00, 32'd2, 0);
      wr(8'h01, 32'd425, 0);
      wr(8'h10, 32'd425, 1);
      @(negedge clk);
      check_eq("pend_busy", W'(pub_if.commit_busy), W'(1));
      check_eq("pend_not_ready", W'(pub_if.wr_ready), W'(0));
      tick(50);
      check_eq("hold_mid_frame", snake_data, reset_image());
      vs = 1'b0;
      exp_frames++;
      @(negedge clk);
      check_eq("pre_edge_done", W'(pub_if.commit_done), W'(0));
      check_eq("pre_edge_data", snake_data, reset_image());
      @(negedge clk);
      check_eq("done_latency", W'(pub_if.commit_done), W'(1));
      check_eq("stage_2", W'(snake_data[359:328]), W'(2));
      check_eq("head1pos_425", W'(snake_data[231:200]), W'(425));
      check_eq("body1_0_425", W'(snake_data[530:520]), W'(425));
      @(negedge clk);
      check_eq("done_one_cycle", W'(pub_if.commit_done), W'(0));
      tick(1);
      vs = 1'b1;
      tick(2);
      check_eq("done_count_1", W'(done_seen), W'(1));

      // writes while pending are dropped
      commit();
      wr(8'h07, 32'd300, 0);
      vsync();
      check_eq("apple_ignored", W'(snake_data[455:424]), W'(2047));
      wr(8'h07, 32'd300, 0);
      commit();
      vsync();
      check_eq("apple_300", W'(snake_data[455:424]), W'(300));
      check_eq("done_count_3", W'(done_seen), W'(3));
      check_eq("err_none", W'(err_seen), W'(exp_err));

      // commit_req in the vs_fall cycle waits for the next edge
      wr(8'h08, 32'd77, 0);
      done_base = done_seen;
      vs = 1'b0;
      exp_frames++;
      commit();
      tick(2);
      vs = 1'b1;
      tick(5);
      check_eq("no_publish_same_edge", W'(done_seen), W'(done_base));
      check_eq("still_busy", W'(pub_if.commit_busy), W'(1));
      check_eq("hearts_unpublished", W'(snake_data[487:456]), W'(0));
      vsync();
      check_eq("next_edge_publish", W'(done_seen), W'(done_base + 1));
      check_eq("hearts_77", W'(snake_data[487:456]), W'(77));

      // address map boundaries, unmapped addresses, LSB truncation
      tbl = '{'{8'hE3, 32'd3}, '{8'h50, 32'd9}, '{8'h09, 32'd1}, '{8'h19, 32'd5},
              '{8'h1A, 32'd6}, '{8'h20, 32'd7}, '{8'h29, 32'hFFFF_F123}, '{8'h2A, 32'd8},
              '{8'h80, 32'hFFFF_FFFE}, '{8'h7F, 32'd1}, '{8'hE4, 32'd2}, '{8'hFF, 32'd3}};
      foreach (tbl[i]) wr(tbl[i].a, tbl[i].d, 0);
      tick(1);
      check_eq("err_count", W'(err_seen), W'(exp_err));
      check_eq("err_expected_7", W'(exp_err), W'(7));
      commit();
      vsync();
      check_eq("dir99_11", W'(snake_data[199:198]), W'(3));
      check_eq("dir0_lsb", W'(snake_data[1:0]), W'(2));
      check_eq("body2_9_lsb", W'(snake_data[739:729]), W'(11'h123));
      check_eq("body1_9", W'(snake_data[629:619]), W'(5));
      check_eq("reserved_zero", W'(snake_data[519:488]), W'(0));
      check_eq("frames_mid", W'(frame_count), W'(exp_frames));

      // reset while pending drops the commit
      commit();
      tick(2);
      check_eq("busy_before_rst", W'(pub_if.commit_busy), W'(1));
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      sb_q.delete();
      pend       = 0;
      m_shadow   = reset_image();
      exp_frames = 0;
      done_base  = done_seen;
      repeat (3) vsync();
      check_eq("rst_no_done", W'(done_seen), W'(done_base));
      check_eq("rst_data_kept", snake_data, reset_image());
      check_eq("rst_frames_3", W'(frame_count), W'(exp_frames));
      check_eq("rst_idle", W'(pub_if.commit_busy), W'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
